// File: rtl/ber_scan_pkg.sv
// Shared state encoding and default measurement constants for the BER phase scan.
package ber_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRST   = 3'd1,
    ST_RUN    = 3'd2,
    ST_EVAL   = 3'd3,
    ST_LRST   = 3'd4,
    ST_LOCKED = 3'd5
  } scan_state_e;

  localparam int unsigned DEF_MEAS_SAMPLES = 4096;
  localparam int unsigned DEF_TIMEOUT      = 32'd1 << 22;

endpackage

// File: rtl/ber_phase_scan.sv
// Sweeps the BER checker over every downsampling phase, measures a fixed sample
// window per phase and locks the checker on the phase with the fewest errors.
module ber_phase_scan
  import ber_scan_pkg::*;
#(
  parameter int unsigned N_PHASES     = 4,
  parameter int unsigned NB_PHASE     = $clog2(N_PHASES),
  parameter int unsigned NB_BER_CNT   = 64,
  parameter int unsigned MEAS_SAMPLES = DEF_MEAS_SAMPLES,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned NB_TMO       = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_BER_CNT-1:0] i_ber_samp,
  input  logic [NB_BER_CNT-1:0] i_ber_error,
  output logic                  o_ber_rst,
  output logic                  o_ber_en,
  output logic [NB_PHASE-1:0]   o_phase_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [NB_PHASE-1:0]   o_best_phase,
  output logic [NB_BER_CNT-1:0] o_best_err,
  output logic                  o_timeout
);

  localparam logic [NB_BER_CNT-1:0] MEAS_THR   = NB_BER_CNT'(MEAS_SAMPLES);
  localparam logic [NB_TMO-1:0]     TMO_LAST   = NB_TMO'(TIMEOUT - 1);
  localparam logic [NB_PHASE-1:0]   PHASE_LAST = NB_PHASE'(N_PHASES - 1);

  scan_state_e           state_q, state_d;
  logic [NB_PHASE-1:0]   phase_idx_q, phase_idx_d;
  logic [NB_TMO-1:0]     tmo_q, tmo_d;
  logic [NB_BER_CNT-1:0] meas_err_q, meas_err_d;
  logic [NB_BER_CNT-1:0] best_err_q, best_err_d;
  logic [NB_PHASE-1:0]   best_phase_q, best_phase_d;

  logic                  ber_rst_q, ber_rst_d;
  logic                  ber_en_q, ber_en_d;
  logic [NB_PHASE-1:0]   phase_sel_q, phase_sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NB_PHASE-1:0]   out_best_phase_q, out_best_phase_d;
  logic [NB_BER_CNT-1:0] out_best_err_q, out_best_err_d;
  logic                  timeout_q, timeout_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q          <= ST_IDLE;
      phase_idx_q      <= '0;
      tmo_q            <= '0;
      meas_err_q       <= '1;
      best_err_q       <= '1;
      best_phase_q     <= '0;
      ber_rst_q        <= 1'b0;
      ber_en_q         <= 1'b0;
      phase_sel_q      <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      out_best_phase_q <= '0;
      out_best_err_q   <= '1;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      phase_idx_q      <= phase_idx_d;
      tmo_q            <= tmo_d;
      meas_err_q       <= meas_err_d;
      best_err_q       <= best_err_d;
      best_phase_q     <= best_phase_d;
      ber_rst_q        <= ber_rst_d;
      ber_en_q         <= ber_en_d;
      phase_sel_q      <= phase_sel_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      out_best_phase_q <= out_best_phase_d;
      out_best_err_q   <= out_best_err_d;
      timeout_q        <= timeout_d;
    end
  end

  // Next-state, measurement tracking and next-output decode
  always_comb begin
    state_d          = state_q;
    phase_idx_d      = phase_idx_q;
    tmo_d            = tmo_q;
    meas_err_d       = meas_err_q;
    best_err_d       = best_err_q;
    best_phase_d     = best_phase_q;
    phase_sel_d      = phase_sel_q;
    out_best_phase_d = out_best_phase_q;
    out_best_err_d   = out_best_err_q;
    timeout_d        = timeout_q;

    case (state_q)
      ST_IDLE, ST_LOCKED: begin
        if (i_start) begin
          state_d      = ST_PRST;
          phase_idx_d  = '0;
          best_err_d   = '1;
          best_phase_d = '0;
          timeout_d    = 1'b0;
        end
      end
      ST_PRST: begin
        tmo_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        tmo_d = tmo_q + NB_TMO'(1);
        // A completed window takes priority over a coincident timeout
        if (i_ber_samp >= MEAS_THR) begin
          meas_err_d = i_ber_error;
          state_d    = ST_EVAL;
        end else if (tmo_q == TMO_LAST) begin
          meas_err_d = '1;
          timeout_d  = 1'b1;
          state_d    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (meas_err_q < best_err_q) begin
          best_err_d   = meas_err_q;
          best_phase_d = phase_idx_q;
        end
        if (phase_idx_q == PHASE_LAST) begin
          state_d          = ST_LRST;
          out_best_phase_d = best_phase_d;
          out_best_err_d   = best_err_d;
        end else begin
          phase_idx_d = phase_idx_q + NB_PHASE'(1);
          state_d     = ST_PRST;
        end
      end
      ST_LRST: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ber_rst_d = (state_d == ST_PRST) || (state_d == ST_LRST);
    ber_en_d  = (state_d == ST_RUN)  || (state_d == ST_LOCKED);
    busy_d    = (state_d == ST_PRST) || (state_d == ST_RUN) ||
                (state_d == ST_EVAL) || (state_d == ST_LRST);
    done_d    = (state_d == ST_LOCKED);

    // Selector changes only when the checker is being reset, so it is stable across each window
    if (state_d == ST_PRST) begin
      phase_sel_d = phase_idx_d;
    end else if (state_d == ST_LRST) begin
      phase_sel_d = best_phase_d;
    end
  end

  assign o_ber_rst    = ber_rst_q;
  assign o_ber_en     = ber_en_q;
  assign o_phase_sel  = phase_sel_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_best_phase = out_best_phase_q;
  assign o_best_err   = out_best_err_q;
  assign o_timeout    = timeout_q;

endmodule

// File: doc/ber_phase_scan.md
# ber_phase_scan

Phase-sweep controller that drives the BER checker's control inputs and consumes its sample/error counters. On a start request it resets the BER checker once per candidate downsampling phase and measures a fixed window of counted samples for each phase. It then re-arms the checker on the phase with the fewest errors and holds it there. It sits directly downstream of the BER counters and upstream of the checker's `i_rst`/`i_en`/`i_phase_sel` pins.

## Interface
Parameters:
- `N_PHASES`, 4, number of candidate phases
- `NB_PHASE`, `$clog2(N_PHASES)`, phase index width
- `NB_BER_CNT`, 64, width of the BER counters
- `MEAS_SAMPLES`, 4096, counted samples per measurement window; must be > 511 (the checker's sync-window length)
- `TIMEOUT`, 2^22, max cycles per phase measurement
- `NB_TMO`, `$clog2(TIMEOUT+1)`, timeout counter width

Ports:
- `clk` in 1: clock
- `i_rst` in 1: reset, synchronous, active-high
- `i_start` in 1: single-cycle start request
- `i_ber_samp` in NB_BER_CNT: BER sample counter
- `i_ber_error` in NB_BER_CNT: BER error counter
- `o_ber_rst` out 1: reset to the BER checker
- `o_ber_en` out 1: enable to the BER checker
- `o_phase_sel` out NB_PHASE: phase selector to the BER checker
- `o_busy` out 1: sweep in progress
- `o_done` out 1: locked on best phase
- `o_best_phase` out NB_PHASE: selected phase
- `o_best_err` out NB_BER_CNT: error count of the selected phase
- `o_timeout` out 1: sticky flag, at least one phase timed out this sweep

## Operation
States: IDLE, PRST, RUN, EVAL, LRST, LOCKED. Encoding lives in the package.

- **IDLE**
  - `o_ber_en`=0.
  - `i_start` → PRST; `phase_idx`=0, `best_err`=all-ones, `best_phase`=0, `o_timeout`=0.
- **PRST** (1 cycle)
  - `o_ber_rst`=1, `o_phase_sel`=`phase_idx`.
  - Timeout counter cleared.
  - → RUN.
- **RUN**
  - `o_ber_en`=1; timeout counter increments.
  - If `i_ber_samp` ≥ MEAS_SAMPLES: capture `meas_err`=`i_ber_error`, → EVAL.
  - Else if counter == TIMEOUT-1: `meas_err`=all-ones, set `o_timeout`, → EVAL.
  - If both hold in the same cycle, the measurement wins.
- **EVAL** (1 cycle)
  - If `meas_err` < `best_err` (strict): update `best_err` and `best_phase`. Ties keep the lower phase.
  - If `phase_idx` == N_PHASES-1 → LRST; else increment `phase_idx` → PRST.
- **LRST** (1 cycle)
  - `o_ber_rst`=1, `o_phase_sel`=`best_phase`.
  - → LOCKED.
- **LOCKED**
  - `o_ber_en`=1, `o_phase_sel`=`best_phase`, `o_done`=1.
  - `i_start` → PRST with a fresh sweep (`best`, `o_timeout` and `phase_idx` cleared as in IDLE).

Other rules:
- `o_busy`=1 in PRST, RUN, EVAL and LRST.
- `i_start` is ignored while busy.
- `o_best_phase`/`o_best_err` update only on the EVAL→LRST transition. They hold from the previous sweep until then.
- The MEAS_SAMPLES > 511 threshold guarantees the window is only reached in the checker's count mode; its sync-mode sample counter never exceeds 510.
- All comparisons are unsigned, at full NB_BER_CNT width.

## Timing
- All outputs are registered.
- Reset values: `o_ber_rst`=0, `o_ber_en`=0, `o_phase_sel`=0, `o_busy`=0, `o_done`=0, `o_best_phase`=0, `o_best_err`=all-ones, `o_timeout`=0. State is IDLE.
- Start to `o_busy`: `i_start` high in cycle t → `o_busy` and `o_ber_rst` high in t+1.
- `o_ber_rst` is exactly one cycle wide per phase and once more for the lock. `o_ber_en` is 0 during every `o_ber_rst` cycle.
- `o_phase_sel` is stable from the PRST/LRST cycle through the end of the following RUN/LOCKED.
- Sample threshold to capture: first cycle with `i_ber_samp` ≥ MEAS_SAMPLES → EVAL next cycle.
- Lock: `o_done` rises 2 cycles after the last EVAL (LRST, then LOCKED).
- `i_rst` mid-sweep: return to IDLE next cycle with reset values. The checker is left disabled (`o_ber_en`=0).

## Structure
- Package `ber_scan_pkg`: state localparams (IDLE..LOCKED, 3-bit) and the default MEAS_SAMPLES/TIMEOUT constants.
- Single module with no sub-module; the timeout counter and best-tracker are inline.
- Expected size: about 200 lines.

## Test plan
- **Nominal sweep:** BER model with phase errors {40, 3, 0, 17} at MEAS_SAMPLES=1024; pulse `i_start` → 4 PRST/RUN cycles, `o_best_phase`=2, `o_best_err`=0, `o_done`=1, `o_phase_sel`=2, one final `o_ber_rst` pulse.
- **Tie:** errors {5, 5, 9, 9} → `o_best_phase`=0.
- **Timeout:** phase 1 model never advances `i_ber_samp`, TIMEOUT=64; errors {7, -, 2, 8} → phase 1 exits after exactly 64 RUN cycles, `o_timeout`=1, `o_best_phase`=2.
- **Sync-mode immunity:** model emits `samp_cnt` wrapping 0..510 for 300 000 cycles before count mode → no EVAL during that period.
- **Mid-sweep reset/restart:** `i_rst` during RUN of phase 2 → all outputs at reset values next cycle; `i_start` while busy has no effect; `i_start` in LOCKED → new sweep with `o_done`=0 in the PRST cycle.
